// File: rtl/spi_stream_pkg.sv
// spi_stream_pkg
// Shared types and constants for the SPI stream bridge: the access-sequencer
// state encoding and the SPI master register addresses.
// No ports.
package spi_stream_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      WR1  = 3'd1,
      WR2  = 3'd2,
      RD1  = 3'd3,
      RD2  = 3'd4,
      GAP  = 3'd5
   } state_t;

   localparam logic [2:0] SPI_ADDR_RXDATA = 3'd0;
   localparam logic [2:0] SPI_ADDR_TXDATA = 3'd1;

endpackage

// File: rtl/spi_stream_fifo.sv
// spi_stream_fifo
// Synchronous FIFO with a combinational head output.
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   push, din         write request / data (ignored when full)
//   pop               read request (ignored when empty)
//   dout              current head entry
//   full, empty       status flags derived from the registered count
//   count             number of stored entries (log2(DEPTH)+1 bits)
module spi_stream_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/spi_stream_bridge.sv
// spi_stream_bridge
// Moves bytes from a valid/ready stream into the SPI master's TX-data register
// through a small FIFO and, when SPI_STREAM_BRIDGE_RX_EN is defined, reads each
// received byte back from the RX-data register onto a second valid/ready stream.
// Ports:
//   clk, reset_n                     clock, asynchronous active-low reset
//   tx_data/tx_valid/tx_ready        upstream byte stream
//   rx_data/rx_valid/rx_ready        downstream byte stream (zero without RX_EN)
//   busy                             FIFO, access or in-flight bytes pending
//   spi_select/spi_mem_addr/spi_data_out/spi_write_n/spi_read_n
//                                    SPI master register port (two-cycle access)
//   spi_data_in                      register read data
//   spi_readyfordata/spi_dataavailable  core TRDY / RRDY
// Build option: SPI_STREAM_BRIDGE_RX_EN enables the receive path.
//
// state | meaning
// IDLE  | pick next access: read first (avoids overrun), then write
// WR1   | TX-data write, first cycle
// WR2   | TX-data write, second cycle; FIFO pops here
// RD1   | RX-data read, first cycle
// RD2   | RX-data read, second cycle; rx register loads here
// GAP   | bus idle so TRDY/RRDY settle before the next decision
module spi_stream_bridge
   import spi_stream_pkg::*;
#(
   parameter int FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [7:0]  tx_data,
   input  logic        tx_valid,
   output logic        tx_ready,
   output logic [7:0]  rx_data,
   output logic        rx_valid,
   input  logic        rx_ready,
   output logic        busy,
   output logic        spi_select,
   output logic [2:0]  spi_mem_addr,
   output logic [15:0] spi_data_out,
   output logic        spi_write_n,
   output logic        spi_read_n,
   input  logic [15:0] spi_data_in,
   input  logic        spi_readyfordata,
   input  logic        spi_dataavailable
);

   state_t state;
   state_t state_nxt;

   logic                        ready_en;
   logic                        fifo_full;
   logic                        fifo_empty;
   logic [7:0]                  fifo_head;
   logic [$clog2(FIFO_DEPTH):0] fifo_count;
   logic [1:0]                  inflight;
   logic                        inflight_inc;
   logic                        inflight_dec;
   logic                        wr_active;
   logic                        rd_active;

   spi_stream_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (tx_valid && tx_ready),
      .din     (tx_data),
      .pop     (state == WR2),
      .dout    (fifo_head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   // Keeps tx_ready low while reset is asserted.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) ready_en <= 1'b0;
      else          ready_en <= 1'b1;
   end

   assign tx_ready = ready_en && !fifo_full;

`ifdef SPI_STREAM_BRIDGE_RX_EN
   logic unused_hi;
   assign unused_hi    = ^{spi_data_in[15:8], fifo_count};
   assign inflight_dec = (state == RD2);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_data  <= 8'h00;
         rx_valid <= 1'b0;
      end else if (state == RD2) begin
         rx_data  <= spi_data_in[7:0];
         rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
         rx_data  <= 8'h00;
         rx_valid <= 1'b0;
      end
   end
`else
   // Without a read path, a byte leaves the core when TRDY rises again.
   logic trdy_q;
   logic unused_rx;
   assign unused_rx    = ^{rx_ready, spi_dataavailable, spi_data_in, fifo_count};
   assign inflight_dec = spi_readyfordata && !trdy_q;
   assign rx_data      = 8'h00;
   assign rx_valid     = 1'b0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) trdy_q <= 1'b0;
      else          trdy_q <= spi_readyfordata;
   end
`endif

   assign inflight_inc = (state == WR2);

   // Decrement saturates at zero: a TRDY edge or a read with nothing counted
   // must not wrap the counter.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         inflight <= 2'd0;
      end else begin
         case ({inflight_inc, inflight_dec && (inflight != 2'd0)})
            2'b10:   inflight <= inflight + 2'd1;
            2'b01:   inflight <= inflight - 2'd1;
            default: inflight <= inflight;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
`ifdef SPI_STREAM_BRIDGE_RX_EN
            if (spi_dataavailable && !rx_valid) state_nxt = RD1;
            else
`endif
            if (!fifo_empty && spi_readyfordata && inflight != 2'd2) state_nxt = WR1;
         end
         WR1:     state_nxt = WR2;
         WR2:     state_nxt = GAP;
         RD1:     state_nxt = RD2;
         RD2:     state_nxt = GAP;
         GAP:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Bus outputs decode straight from the state register so an asynchronous
   // reset idles the bus immediately.
   assign wr_active    = (state == WR1) || (state == WR2);
   assign rd_active    = (state == RD1) || (state == RD2);
   assign spi_select   = wr_active || rd_active;
   assign spi_write_n  = !wr_active;
   assign spi_read_n   = !rd_active;
   assign spi_mem_addr = wr_active ? SPI_ADDR_TXDATA : SPI_ADDR_RXDATA;
   assign spi_data_out = wr_active ? {8'h00, fifo_head} : 16'h0000;

   assign busy = !fifo_empty || (state != IDLE) || (inflight != 2'd0);

endmodule

// File: tb/tb_spi_stream_bridge.sv
module tb_spi_stream_bridge;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [7:0]  tx_data = 8'h00;
   logic        tx_valid = 1'b0;
   logic        tx_ready;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready = 1'b0;
   logic        busy;
   logic        spi_select;
   logic [2:0]  spi_mem_addr;
   logic [15:0] spi_data_out;
   logic        spi_write_n;
   logic        spi_read_n;
   logic [15:0] spi_data_in = 16'h0000;
   logic        spi_readyfordata = 1'b0;
   logic        spi_dataavailable = 1'b0;

   spi_stream_bridge #(.FIFO_DEPTH(8)) dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .tx_data           (tx_data),
      .tx_valid          (tx_valid),
      .tx_ready          (tx_ready),
      .rx_data           (rx_data),
      .rx_valid          (rx_valid),
      .rx_ready          (rx_ready),
      .busy              (busy),
      .spi_select        (spi_select),
      .spi_mem_addr      (spi_mem_addr),
      .spi_data_out      (spi_data_out),
      .spi_write_n       (spi_write_n),
      .spi_read_n        (spi_read_n),
      .spi_data_in       (spi_data_in),
      .spi_readyfordata  (spi_readyfordata),
      .spi_dataavailable (spi_dataavailable)
   );

   always #10 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Bus monitor: counts access starts and logs written bytes.
   int         wr_acc = 0;
   int         rd_acc = 0;
   int         rxv_cyc = 0;
   logic       wr_q = 1'b0;
   logic       rd_q = 1'b0;
   logic [7:0] wr_log [32];

   always @(negedge clk) begin
      if (!spi_write_n && !wr_q) begin
         if (wr_acc < 32) wr_log[wr_acc] = spi_data_out[7:0];
         wr_acc++;
      end
      if (!spi_read_n && !rd_q) rd_acc++;
      if (rx_valid) rxv_cyc++;
      wr_q = !spi_write_n;
      rd_q = !spi_read_n;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int snap;
      int k;

      // Reset values
      tick(2);
      check("rst_tx_ready", tx_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_select", spi_select, 0);
      check("rst_write_n", spi_write_n, 1);
      check("rst_read_n", spi_read_n, 1);
      check("rst_addr", spi_mem_addr, 0);
      check("rst_data_out", spi_data_out, 0);
      check("rst_rx_valid", rx_valid, 0);
      check("rst_rx_data", rx_data, 0);
      reset_n = 1'b1;
      tick(1);
      check("tx_ready_after_rst", tx_ready, 1);

      // Single byte write
      spi_readyfordata = 1'b1;
      tx_data = 8'hA5;
      tx_valid = 1'b1;
      tick(1);
      tx_valid = 1'b0;
      check("single_busy_push", busy, 1);
      check("single_not_yet", spi_write_n, 1);
      tick(1);
      check("wr1_select", spi_select, 1);
      check("wr1_write_n", spi_write_n, 0);
      check("wr1_addr", spi_mem_addr, 1);
      check("wr1_data", spi_data_out, 16'h00A5);
      tick(1);
      check("wr2_write_n", spi_write_n, 0);
      check("wr2_data", spi_data_out, 16'h00A5);
      tick(1);
      check("gap_write_n", spi_write_n, 1);
      check("gap_select", spi_select, 0);
      check("gap_busy", busy, 1);
`ifdef SPI_STREAM_BRIDGE_RX_EN
      spi_dataavailable = 1'b1;
      spi_data_in = 16'hAB3C;
      tick(1);
      check("rd1_read_n", spi_read_n, 0);
      check("rd1_select", spi_select, 1);
      check("rd1_addr", spi_mem_addr, 0);
      check("rd1_write_n", spi_write_n, 1);
      tick(1);
      check("rd2_read_n", spi_read_n, 0);
      tick(1);
      check("rx_valid_after_rd2", rx_valid, 1);
      check("rx_data_after_rd2", rx_data, 8'h3C);
      check("rx_gap_read_n", spi_read_n, 1);
      spi_dataavailable = 1'b0;
      rx_ready = 1'b1;
      tick(1);
      check("rx_handshake_clear", rx_valid, 0);
      check("single_busy_done", busy, 0);
      rx_ready = 1'b0;
`else
      spi_readyfordata = 1'b0;
      tick(1);
      spi_readyfordata = 1'b1;
      tick(1);
      check("single_busy_done", busy, 0);
`endif

      // FIFO full and push refused on the pop cycle
      spi_readyfordata = 1'b0;
      for (int i = 0; i < 9; i++) begin
         tx_data = 8'h10 + 8'(i);
         tx_valid = 1'b1;
         check("tx_ready_fill", tx_ready, (i < 8) ? 1 : 0);
         tick(1);
      end
      tick(2);
      check("full_hold", tx_ready, 0);
      spi_readyfordata = 1'b1;
      tick(1);
      check("full_wr1_write_n", spi_write_n, 0);
      check("full_wr1_data", spi_data_out, 16'h0010);
      check("full_wr1_ready", tx_ready, 0);
      tick(1);
      check("full_wr2_ready", tx_ready, 0);
      tick(1);
      check("pop_frees_slot", tx_ready, 1);
      tick(1);
      tx_valid = 1'b0;
      check("ninth_accepted", tx_ready, 0);
      tick(1);
      check("second_wr1", spi_write_n, 0);
      tick(1);
      check("second_wr2_data", spi_data_out, 16'h0011);

      // Reset in the middle of WR2
      #2;
      reset_n = 1'b0;
      #1;
      check("midrst_write_n", spi_write_n, 1);
      check("midrst_select", spi_select, 0);
      check("midrst_data_out", spi_data_out, 0);
      check("midrst_busy", busy, 0);
      check("midrst_tx_ready", tx_ready, 0);
      tick(1);
      reset_n = 1'b1;
      tick(1);
      check("postrst_busy", busy, 0);
      check("postrst_tx_ready", tx_ready, 1);
      snap = wr_acc;
      tick(5);
      check("postrst_fifo_empty", wr_acc - snap, 0);

`ifdef SPI_STREAM_BRIDGE_RX_EN
      // Read takes priority over a pending write
      spi_readyfordata = 1'b0;
      tx_data = 8'h77;
      tx_valid = 1'b1;
      tick(1);
      tx_valid = 1'b0;
      spi_readyfordata = 1'b1;
      spi_dataavailable = 1'b1;
      spi_data_in = 16'h0055;
      tick(1);
      check("prio_read_first", spi_read_n, 0);
      check("prio_no_write", spi_write_n, 1);
      tick(2);
      check("prio_rx_valid", rx_valid, 1);
      check("prio_rx_data", rx_data, 8'h55);
      spi_dataavailable = 1'b0;
      rx_ready = 1'b1;
      tick(1);
      rx_ready = 1'b0;
      tick(1);
      check("prio_then_write", spi_write_n, 0);
      check("prio_write_data", spi_data_out, 16'h0077);
      tick(2);

      // rx backpressure
      spi_dataavailable = 1'b1;
      spi_data_in = 16'h0099;
      k = 0;
      while (!rx_valid && k < 10) begin
         tick(1);
         k++;
      end
      check("bp_rx_valid", rx_valid, 1);
      check("bp_rx_data", rx_data, 8'h99);
      snap = rd_acc;
      tick(6);
      check("bp_no_read", rd_acc - snap, 0);
      check("bp_bus_idle", spi_select, 0);
      rx_ready = 1'b1;
      k = 0;
      while (spi_read_n && k < 3) begin
         tick(1);
         k++;
      end
      check("bp_read_resumes", spi_read_n, 0);
      rx_ready = 1'b0;
      spi_dataavailable = 1'b0;
      tick(4);
`else
      // Transmit-only streaming of 4 bytes
      spi_readyfordata = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tx_data = 8'hC1 + 8'(i);
         tx_valid = 1'b1;
         tick(1);
      end
      tx_valid = 1'b0;
      snap = wr_acc;
      for (int c = 0; c < 80; c++) begin
         spi_readyfordata = ((c % 4) < 2);
         tick(1);
      end
      check("stream_writes", wr_acc - snap, 4);
      for (int i = 0; i < 4; i++)
         check("stream_byte", wr_log[snap + i], 8'hC1 + 8'(i));
      check("stream_busy_done", busy, 0);
      check("txonly_no_reads", rd_acc, 0);
      check("txonly_rx_valid", rxv_cyc, 0);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
